// File: rtl/clk_edge_tracker_pkg.sv
// Shared definitions for the clock-edge tracker: tracker states and the
// width of the free-running rising-edge counter.
package clk_edge_tracker_pkg;

    typedef enum logic [1:0] {
        LOST    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } tracker_state_e;

    localparam int RISE_COUNT_W = 16;

endpackage

// File: rtl/clk_edge_tracker_sync_ff.sv
// Multi-stage synchronizer that brings the asynchronous divided clock into
// the clk_src domain; legal stage counts are 2..4.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_src,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_edge_tracker.sv
// Tracks a divided clock from the clk_src domain: edge strobes, rising-edge
// period measurement with saturation, and loss-of-clock detection.
module clk_edge_tracker
    import clk_edge_tracker_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64,
    parameter int PERIOD_BITS = 8
) (
    input  logic                    clk_src,
    input  logic                    reset_n,
    input  logic                    clk_in,
    output logic                    en_rise,
    output logic                    en_fall,
    output logic [PERIOD_BITS-1:0]  period,
    output logic                    period_valid,
    output logic                    clk_lost,
    output logic [RISE_COUNT_W-1:0] rise_count
);

    localparam int IDLE_W = 16;
    localparam logic [IDLE_W-1:0]      IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [PERIOD_BITS-1:0] SINCE_MAX = '1;

    logic                    clk_sync;
    logic                    clk_hist;
    logic                    rise_det;
    logic                    fall_det;
    logic                    any_edge;
    logic                    timeout_hit;
    logic                    load_period;
    logic [PERIOD_BITS-1:0]  since_rise;
    logic [IDLE_W-1:0]       idle;
    logic [IDLE_W-1:0]       idle_next;
    logic [RISE_COUNT_W-1:0] rise_cnt_q;
    tracker_state_e          state;
    tracker_state_e          state_next;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_src (clk_src),
        .reset_n (reset_n),
        .d       (clk_in),
        .q       (clk_sync)
    );

    assign rise_det = clk_sync & ~clk_hist;
    assign fall_det = ~clk_sync & clk_hist;
    assign any_edge = rise_det | fall_det;

    // A detected edge always clears idle, so an edge arriving on the cycle
    // idle would have reached TIMEOUT keeps the tracker out of LOST.
    always_comb begin
        idle_next = idle;
        if (any_edge) begin
            idle_next = '0;
        end else if (idle != IDLE_MAX) begin
            idle_next = idle + 1'b1;
        end
        timeout_hit = !any_edge && (idle_next == IDLE_MAX);
    end

    always_comb begin
        state_next  = state;
        load_period = 1'b0;
        case (state)
            LOST: begin
                if (rise_det) begin
                    state_next = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (rise_det) begin
                    state_next  = LOCKED;
                    load_period = 1'b1;
                end
            end
            LOCKED: begin
                if (rise_det) begin
                    load_period = 1'b1;
                end
            end
            default: state_next = LOST;
        endcase
        if (timeout_hit) begin
            state_next = LOST;
        end
    end

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            state    <= LOST;
            clk_hist <= 1'b0;
            en_rise  <= 1'b0;
            en_fall  <= 1'b0;
            idle     <= '0;
        end else begin
            state    <= state_next;
            clk_hist <= clk_sync;
            en_rise  <= rise_det;
            en_fall  <= fall_det;
            idle     <= idle_next;
        end
    end

    // since_rise restarts at 1 on the edge that raises en_rise, so the value
    // seen at the next rising edge equals the rise-to-rise distance.
    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            since_rise <= '0;
            period     <= '0;
            rise_cnt_q <= '0;
        end else begin
            if (rise_det) begin
                since_rise <= PERIOD_BITS'(1);
                rise_cnt_q <= rise_cnt_q + 1'b1;
            end else if (since_rise != SINCE_MAX) begin
                since_rise <= since_rise + 1'b1;
            end
            if (load_period) begin
                period <= since_rise;
            end
        end
    end

    assign period_valid = (state == LOCKED);
    assign clk_lost     = (state == LOST);
    assign rise_count   = rise_cnt_q;

endmodule
